// File: rtl/led_button_pkg.sv
// Shared register map and debounce state encoding for the LED push-button controller.
package led_button_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

endpackage

// File: rtl/button_debounce_cell.sv
// One button: 2-FF synchroniser, stability counter and accept FSM.
// Outputs the debounced level and a one-cycle press pulse on the edge where it falls.
module button_debounce_cell
    import led_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stable_nxt;

    // Synchroniser and stable level reset high: buttons are active-low, so "released".
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            state   <= DB_IDLE;
            cnt     <= '0;
            stable  <= 1'b1;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stable  <= stable_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        press      = 1'b0;
        case (state)
            DB_IDLE: begin
                if (sync_q2 != stable) begin
                    state_nxt = DB_COUNT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            DB_COUNT: begin
                if (sync_q2 == stable) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // Accept: a falling level (stable was 1) is a press.
                    stable_nxt = sync_q2;
                    state_nxt  = DB_IDLE;
                    cnt_nxt    = '0;
                    press      = stable;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/led_button_debounce_ctrl.sv
// Avalon-MM push-button controller: debounced level, sticky press capture (W1C),
// interrupt mask and a registered level interrupt.
module led_button_debounce_ctrl
    import led_button_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             wdata_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        button_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .pin   (in_port[i]),
            .stable(stable[i]),
            .press (press[i])
        );
    end

    assign wr_en        = chipselect & ~write_n;
    assign edgecap_clr  = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    // Bits above WIDTH are ignored on write.
    assign wdata_unused = ^(writedata >> WIDTH);

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = ~stable;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
            default:      rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(edgecap & irqmask);
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // OR-ing the press in after the clear makes a same-edge press win over W1C.
            edgecap <= (edgecap & ~edgecap_clr) | press;
        end
    end

endmodule
